alu_pair_seq: RTL and testbench
===============================

Name: alu_pair_seq

Overview:
- Multi-cycle sequencer that runs 16-bit register-pair arithmetic on the existing 8-bit ALU: addp, adcp, subp, sbcp and cmpp.
- Each operation is issued as two 8-bit ALU passes: low byte first, then high byte, chaining the carry between them.
- Sits between the instruction decode/execute stage and the ALU.
- Owns the ALU operand/opcode muxing for the duration of a pair op.
- Produces the 16-bit result, a result write enable, and the merged processor flags.

Parameters:
- DATA_W, 8, ALU byte width; pair width is 2*DATA_W.
- PF_W, 4, processor-flags vector width.
- PF_C, 1, bit index of the carry flag within the flags vector.
- PF_Z, 0, bit index of the zero flag within the flags vector.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  3  pair op: 0=addp, 1=adcp, 2=subp, 3=sbcp, 4=cmpp; 5..7 reserved.
- a_in  in  2*DATA_W  operand A (pair).
- b_in  in  2*DATA_W  operand B (pair).
- flags_in  in  PF_W  current processor flags.
- alu_oper  out  pkg_alu::alu_oper  opcode driven to the ALU.
- alu_a_lo  out  DATA_W  ALU a_in_lo.
- alu_b  out  DATA_W  ALU b_in.
- alu_flags_in  out  PF_W  ALU proc_flags_in.
- alu_out_lo  in  DATA_W  ALU byte result.
- alu_flags_out  in  PF_W  ALU flags result; only bit PF_C is consumed.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle completion pulse.
- result  out  2*DATA_W  pair result; valid while done=1, held afterwards.
- result_we  out  1  write enable for result, qualified with done.
- flags_out  out  PF_W  updated flags; valid while done=1, held afterwards.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high (port reset).
- Reset values: state=IDLE; busy=0; done=0; result_we=0; result=0; flags_out=0; alu_oper=alu_op_add; alu_a_lo=0; alu_b=0; alu_flags_in=0.
- FSM states: IDLE, LO, HI, FIN.

IDLE:
- On start=1 with a legal op: latch a_in, b_in, op and flags_in into registers; go to LO.
- On start=1 with a reserved op: ignore, stay in IDLE.

LO:
- Drive alu_a_lo=a_q[7:0] and alu_b=b_q[7:0].
- Drive alu_flags_in = latched flags, except that for addp/subp/cmpp the C bit is forced to 0 (it is not used).
- Drive alu_oper: add for addp, adc for adcp, sub for subp and cmpp, sbc for sbcp.
- Register lo_q=alu_out_lo and c_q=alu_flags_out[PF_C]; go to HI.

HI:
- Drive the high bytes; alu_flags_in[PF_C]=c_q.
- Drive alu_oper: adc for addp/adcp, sbc for subp/sbcp/cmpp.
- Register hi_q=alu_out_lo and the final C; go to FIN.

FIN:
- done=1.
- result={hi_q,lo_q}.
- result_we=1 except for cmpp, where it is 0.
- flags_out = latched flags with C=final carry and Z=({hi_q,lo_q}==0). All other flag bits pass through unchanged.
- Go to IDLE.

Timing and arithmetic rules:
- Latency: start accepted at edge t gives done high in the cycle after edge t+3. Back-to-back: the next start is accepted in the cycle after done (IDLE). One op per 4 cycles.
- Subtraction carry convention is no-borrow (a+~b+carry), so C=1 means no borrow.
- The ALU's 8-bit Z output is ignored; Z is computed over the full 16 bits by this block.
- Operand inputs are don't-care outside the accept cycle.
- start while busy is ignored (no queueing, no error).
- Reset asserted in any state: next state IDLE, done=0, result_we=0, with no partial result or flag commit.
- alu_* outputs are held at their reset values while in IDLE and FIN, so the ALU sees no spurious shift-op side effects.

Test Plan:
1. addp, a=0x12FF, b=0x0001, flags_in=0 -> done exactly 4 cycles after the start edge; result=0x1300, result_we=1, C=0, Z=0; the LO phase drives add and the HI phase drives adc with C=1.
2. addp, a=0xFFFF, b=0x0001 -> result=0x0000, C=1, Z=1; non-C/Z flag bits of flags_in=0b1100 appear unchanged in flags_out.
3. subp, a=0x1000, b=0x0001 -> result=0x0FFF, C=1. Then sbcp, a=0x0005, b=0x0005 with flags_in C=0 -> result=0xFFFF, C=0, Z=0.
4. cmpp, a=0x1234, b=0x1234 -> done=1, result_we=0, Z=1, C=1. Repeat with b=0x1235 -> Z=0, C=0.
5. Hold start=1 continuously, issuing addp then subp -> second op accepted only in the cycle after the first done; done pulses are exactly 4 cycles apart. Also: op=6 -> no busy, no done.
6. Assert reset during HI -> next cycle IDLE, busy=0, done never pulses, result/flags_out at reset values. A fresh addp then completes normally.

Source files
------------

// File: rtl/alu_pair_seq.sv
// 16-bit register-pair arithmetic (addp/adcp/subp/sbcp/cmpp) sequenced as two
// carry-chained passes through the shared 8-bit ALU, low byte first.
package pkg_alu;
  typedef enum logic [3:0] {
    alu_op_add = 4'd0,
    alu_op_adc,
    alu_op_sub,
    alu_op_sbc,
    alu_op_and,
    alu_op_or,
    alu_op_xor,
    alu_op_shl,
    alu_op_shr
  } alu_oper;
endpackage

module alu_pair_seq #(
  parameter int DATA_W = 8,
  parameter int PF_W   = 4,
  parameter int PF_C   = 1,
  parameter int PF_Z   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [2*DATA_W-1:0]   a_in,
  input  logic [2*DATA_W-1:0]   b_in,
  input  logic [PF_W-1:0]       flags_in,
  output pkg_alu::alu_oper      alu_oper,
  output logic [DATA_W-1:0]     alu_a_lo,
  output logic [DATA_W-1:0]     alu_b,
  output logic [PF_W-1:0]       alu_flags_in,
  input  logic [DATA_W-1:0]     alu_out_lo,
  input  logic [PF_W-1:0]       alu_flags_out,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   result,
  output logic                  result_we,
  output logic [PF_W-1:0]       flags_out
);

  localparam int PW = 2 * DATA_W;

  typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_FIN} state_t;
  typedef enum logic [2:0] {OP_ADDP, OP_ADCP, OP_SUBP, OP_SBCP, OP_CMPP} pair_op_t;

  state_t            state_q, state_d;
  pair_op_t          op_q, op_d;
  logic [PW-1:0]     a_q, a_d, b_q, b_d;
  logic [PF_W-1:0]   fl_q, fl_d;
  logic [DATA_W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic              c_q, c_d;
  logic              busy_q, busy_d, done_q, done_d, result_we_q, result_we_d;
  logic [PW-1:0]     result_q, result_d;
  logic [PF_W-1:0]   flags_out_q, flags_out_d;

  // Only the carry is taken from the ALU flags; the byte-wide Z is meaningless here.
  logic unused_alu_flags;
  assign unused_alu_flags = ^alu_flags_out;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    fl_d        = fl_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    c_d         = c_q;
    done_d      = 1'b0;
    result_we_d = 1'b0;
    result_d    = result_q;
    flags_out_d = flags_out_q;
    case (state_q)
      ST_IDLE: begin
        if (start && (op <= 3'd4)) begin
          a_d     = a_in;
          b_d     = b_in;
          op_d    = pair_op_t'(op);
          fl_d    = flags_in;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        lo_d    = alu_out_lo;
        c_d     = alu_flags_out[PF_C];
        state_d = ST_HI;
      end
      ST_HI: begin
        hi_d    = alu_out_lo;
        c_d     = alu_flags_out[PF_C];
        state_d = ST_FIN;
      end
      ST_FIN: begin
        done_d            = 1'b1;
        result_we_d       = (op_q != OP_CMPP);
        result_d          = {hi_q, lo_q};
        flags_out_d       = fl_q;
        flags_out_d[PF_C] = c_q;
        flags_out_d[PF_Z] = ({hi_q, lo_q} == '0);
        state_d           = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // ALU operand/opcode mux; parked at the add/zero idle values outside LO and HI.
  always_comb begin
    alu_oper     = pkg_alu::alu_op_add;
    alu_a_lo     = '0;
    alu_b        = '0;
    alu_flags_in = '0;
    case (state_q)
      ST_LO: begin
        alu_a_lo     = a_q[DATA_W-1:0];
        alu_b        = b_q[DATA_W-1:0];
        alu_flags_in = fl_q;
        case (op_q)
          OP_ADCP: alu_oper = pkg_alu::alu_op_adc;
          OP_SBCP: alu_oper = pkg_alu::alu_op_sbc;
          OP_ADDP: begin
            alu_oper           = pkg_alu::alu_op_add;
            alu_flags_in[PF_C] = 1'b0;
          end
          default: begin
            alu_oper           = pkg_alu::alu_op_sub;
            alu_flags_in[PF_C] = 1'b0;
          end
        endcase
      end
      ST_HI: begin
        alu_a_lo           = a_q[PW-1:DATA_W];
        alu_b              = b_q[PW-1:DATA_W];
        alu_flags_in       = fl_q;
        alu_flags_in[PF_C] = c_q;
        alu_oper           = ((op_q == OP_ADDP) || (op_q == OP_ADCP)) ?
                             pkg_alu::alu_op_adc : pkg_alu::alu_op_sbc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADDP;
      a_q         <= '0;
      b_q         <= '0;
      fl_q        <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      c_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_we_q <= 1'b0;
      result_q    <= '0;
      flags_out_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fl_q        <= fl_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      c_q         <= c_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_we_q <= result_we_d;
      result_q    <= result_d;
      flags_out_q <= flags_out_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_we = result_we_q;
  assign result    = result_q;
  assign flags_out = flags_out_q;

endmodule

// File: tb/tb_alu_pair_seq.sv
// Bench for alu_pair_seq: behavioural 8-bit ALU attached to the DUT, and a
// 16-bit arithmetic reference model for the expected pair results and flags.
module tb_alu_pair_seq;

  logic             clk, reset, start;
  logic [2:0]       op;
  logic [15:0]      a_in, b_in, result;
  logic [3:0]       flags_in, alu_flags_in, alu_flags_out, flags_out;
  pkg_alu::alu_oper alu_oper;
  logic [7:0]       alu_a_lo, alu_b, alu_out_lo;
  logic             busy, done, result_we;
  logic [8:0]       alu_sum;

  int checks = 0;
  int errors = 0;

  alu_pair_seq #(.DATA_W(8), .PF_W(4), .PF_C(1), .PF_Z(0)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .flags_in(flags_in), .alu_oper(alu_oper), .alu_a_lo(alu_a_lo), .alu_b(alu_b),
    .alu_flags_in(alu_flags_in), .alu_out_lo(alu_out_lo), .alu_flags_out(alu_flags_out),
    .busy(busy), .done(done), .result(result), .result_we(result_we), .flags_out(flags_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte ALU model; non-carry flag bits are deliberately junk so leaks show up.
  always_comb begin
    alu_sum = '0;
    case (alu_oper)
      pkg_alu::alu_op_add: alu_sum = {1'b0, alu_a_lo} + {1'b0, alu_b};
      pkg_alu::alu_op_adc: alu_sum = {1'b0, alu_a_lo} + {1'b0, alu_b} + {8'd0, alu_flags_in[1]};
      pkg_alu::alu_op_sub: alu_sum = {1'b0, alu_a_lo} + {1'b0, ~alu_b} + 9'd1;
      pkg_alu::alu_op_sbc: alu_sum = {1'b0, alu_a_lo} + {1'b0, ~alu_b} + {8'd0, alu_flags_in[1]};
      default:             alu_sum = {1'b0, alu_a_lo ^ alu_b};
    endcase
    alu_out_lo       = alu_sum[7:0];
    alu_flags_out    = ~alu_flags_in;
    alu_flags_out[1] = alu_sum[8];
    alu_flags_out[0] = (alu_sum[7:0] == 8'd0);
  end

  function automatic void ref_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] f, output logic [15:0] r,
                                 output logic [3:0] fo, output logic we);
    logic [16:0] s;
    case (o)
      3'd0:       s = {1'b0, a} + {1'b0, b};
      3'd1:       s = {1'b0, a} + {1'b0, b} + {16'd0, f[1]};
      3'd2, 3'd4: s = {1'b0, a} + {1'b0, ~b} + 17'd1;
      3'd3:       s = {1'b0, a} + {1'b0, ~b} + {16'd0, f[1]};
      default:    s = '0;
    endcase
    r     = s[15:0];
    fo    = f;
    fo[1] = s[16];
    fo[0] = (r == 16'd0);
    we    = (o != 3'd4);
  endfunction

  // Issues one op from IDLE and collects what the DUT shows; lat=-1 if done never came.
  task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] f, output int lat, output logic [15:0] res,
                        output logic we, output logic [3:0] fo,
                        output pkg_alu::alu_oper lo_op, output pkg_alu::alu_oper hi_op,
                        output logic hi_c);
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b; flags_in = f;
    @(posedge clk); #1;
    start = 1'b0; a_in = 16'($urandom); b_in = 16'($urandom); flags_in = 4'($urandom);
    lat = -1; res = '0; we = 1'b0; fo = '0; hi_c = 1'b0;
    lo_op = pkg_alu::alu_op_xor; hi_op = pkg_alu::alu_op_xor;
    for (int k = 0; k < 12; k++) begin
      if (k == 0) lo_op = alu_oper;
      if (k == 1) begin hi_op = alu_oper; hi_c = alu_flags_in[1]; end
      if (done === 1'b1) begin
        lat = k; res = result; we = result_we; fo = flags_out;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0; flags_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (result_we !== 1'b0) begin errors++; $display("FAIL rst_we got=%b exp=0", result_we); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL rst_result got=%h exp=0000", result); end
    checks++; if (flags_out !== 4'h0) begin errors++; $display("FAIL rst_flags got=%b exp=0000", flags_out); end
    checks++; if (alu_oper !== pkg_alu::alu_op_add || alu_a_lo !== 8'h00 || alu_b !== 8'h00 || alu_flags_in !== 4'h0) begin
      errors++; $display("FAIL rst_alu got=%0d/%h/%h/%b exp=0/00/00/0000", alu_oper, alu_a_lo, alu_b, alu_flags_in);
    end
    reset = 1'b0;
  endtask

  task automatic test_addp;
    int lat; logic [15:0] res; logic we, hc; logic [3:0] fo; pkg_alu::alu_oper lo_op, hi_op;
    run_op(3'd0, 16'h12FF, 16'h0001, 4'b0000, lat, res, we, fo, lo_op, hi_op, hc);
    checks++; if (lat !== 3) begin errors++; $display("FAIL addp_latency got=%0d exp=3", lat); end
    checks++; if (res !== 16'h1300) begin errors++; $display("FAIL addp_result got=%h exp=1300", res); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL addp_we got=%b exp=1", we); end
    checks++; if (fo !== 4'b0000) begin errors++; $display("FAIL addp_flags got=%b exp=0000", fo); end
    checks++; if (lo_op !== pkg_alu::alu_op_add) begin errors++; $display("FAIL addp_lo_op got=%0d exp=%0d", lo_op, pkg_alu::alu_op_add); end
    checks++; if (hi_op !== pkg_alu::alu_op_adc) begin errors++; $display("FAIL addp_hi_op got=%0d exp=%0d", hi_op, pkg_alu::alu_op_adc); end
    checks++; if (hc !== 1'b1) begin errors++; $display("FAIL addp_hi_carry got=%b exp=1", hc); end
    run_op(3'd0, 16'hFFFF, 16'h0001, 4'b1100, lat, res, we, fo, lo_op, hi_op, hc);
    checks++; if (res !== 16'h0000) begin errors++; $display("FAIL addp_wrap_result got=%h exp=0000", res); end
    checks++; if (fo !== 4'b1111) begin errors++; $display("FAIL addp_wrap_flags got=%b exp=1111", fo); end
  endtask

  task automatic test_subp_sbcp;
    int lat; logic [15:0] res; logic we, hc; logic [3:0] fo; pkg_alu::alu_oper lo_op, hi_op;
    run_op(3'd2, 16'h1000, 16'h0001, 4'b0000, lat, res, we, fo, lo_op, hi_op, hc);
    checks++; if (res !== 16'h0FFF) begin errors++; $display("FAIL subp_result got=%h exp=0fff", res); end
    checks++; if (fo !== 4'b0010) begin errors++; $display("FAIL subp_flags got=%b exp=0010", fo); end
    run_op(3'd3, 16'h0005, 16'h0005, 4'b0000, lat, res, we, fo, lo_op, hi_op, hc);
    checks++; if (res !== 16'hFFFF) begin errors++; $display("FAIL sbcp_result got=%h exp=ffff", res); end
    checks++; if (fo !== 4'b0000) begin errors++; $display("FAIL sbcp_flags got=%b exp=0000", fo); end
  endtask

  task automatic test_cmpp;
    int lat; logic [15:0] res; logic we, hc; logic [3:0] fo; pkg_alu::alu_oper lo_op, hi_op;
    run_op(3'd4, 16'h1234, 16'h1234, 4'b0000, lat, res, we, fo, lo_op, hi_op, hc);
    checks++; if (lat !== 3) begin errors++; $display("FAIL cmpp_latency got=%0d exp=3", lat); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL cmpp_we got=%b exp=0", we); end
    checks++; if (fo !== 4'b0011) begin errors++; $display("FAIL cmpp_eq_flags got=%b exp=0011", fo); end
    run_op(3'd4, 16'h1234, 16'h1235, 4'b1000, lat, res, we, fo, lo_op, hi_op, hc);
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL cmpp_ne_we got=%b exp=0", we); end
    checks++; if (fo !== 4'b1000) begin errors++; $display("FAIL cmpp_ne_flags got=%b exp=1000", fo); end
  endtask

  task automatic test_random;
    int lat; logic [15:0] res, a, b, er; logic we, hc, ew; logic [3:0] fo, f, ef;
    logic [2:0] o; pkg_alu::alu_oper lo_op, hi_op;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 4));
      a = 16'($urandom);
      b = (i % 5 == 0) ? a : 16'($urandom);
      f = 4'($urandom);
      ref_op(o, a, b, f, er, ef, ew);
      run_op(o, a, b, f, lat, res, we, fo, lo_op, hi_op, hc);
      checks++; if (lat !== 3) begin errors++; $display("FAIL rand_latency[%0d] got=%0d exp=3", i, lat); end
      checks++; if (res !== er) begin errors++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, res, er); end
      checks++; if (we !== ew) begin errors++; $display("FAIL rand_we[%0d] got=%b exp=%b", i, we, ew); end
      checks++; if (fo !== ef) begin errors++; $display("FAIL rand_flags[%0d] op=%0d got=%b exp=%b", i, o, fo, ef); end
    end
  endtask

  task automatic test_back_to_back;
    int first, second, ndone; logic [15:0] r1, r2, e1, e2; logic [3:0] f2, ef1, ef2; logic ew;
    ref_op(3'd0, 16'h00F0, 16'h0010, 4'b0000, e1, ef1, ew);
    ref_op(3'd2, 16'h8000, 16'h0001, 4'b0100, e2, ef2, ew);
    first = -1; second = -1; ndone = 0; r1 = '0; r2 = '0; f2 = '0;
    @(negedge clk);
    start = 1'b1; op = 3'd0; a_in = 16'h00F0; b_in = 16'h0010; flags_in = 4'b0000;
    @(posedge clk); #1;
    op = 3'd2; a_in = 16'h8000; b_in = 16'h0001; flags_in = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      if (k < 3) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy[%0d] got=%b exp=1", k, busy); end
      end
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) begin first = k; r1 = result; end
        else if (second < 0) begin second = k; r2 = result; f2 = flags_out; end
      end
      if (k == 7) start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++; if (first !== 3) begin errors++; $display("FAIL b2b_first_done got=%0d exp=3", first); end
    checks++; if (second !== 7) begin errors++; $display("FAIL b2b_second_done got=%0d exp=7", second); end
    checks++; if (ndone !== 2) begin errors++; $display("FAIL b2b_done_cycles got=%0d exp=2", ndone); end
    checks++; if (r1 !== e1) begin errors++; $display("FAIL b2b_result1 got=%h exp=%h", r1, e1); end
    checks++; if (r2 !== e2) begin errors++; $display("FAIL b2b_result2 got=%h exp=%h", r2, e2); end
    checks++; if (f2 !== ef2) begin errors++; $display("FAIL b2b_flags2 got=%b exp=%b", f2, ef2); end
  endtask

  task automatic test_reserved;
    @(negedge clk);
    start = 1'b1; op = 3'd6; a_in = 16'h1111; b_in = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL reserved_op[%0d] got busy=%b done=%b exp=0/0", k, busy, done);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid;
    int lat, seen; logic [15:0] res; logic we, hc; logic [3:0] fo; pkg_alu::alu_oper lo_op, hi_op;
    @(negedge clk);
    start = 1'b1; op = 3'd0; a_in = 16'h1234; b_in = 16'h1111; flags_in = 4'b1010;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || result_we !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl got busy=%b done=%b we=%b exp=0/0/0", busy, done, result_we);
    end
    checks++; if (result !== 16'h0000 || flags_out !== 4'h0) begin
      errors++; $display("FAIL midrst_outputs got=%h/%b exp=0000/0000", result, flags_out);
    end
    checks++; if (alu_oper !== pkg_alu::alu_op_add || alu_a_lo !== 8'h00 || alu_b !== 8'h00 || alu_flags_in !== 4'h0) begin
      errors++; $display("FAIL midrst_alu got=%0d/%h/%h/%b exp=0/00/00/0000", alu_oper, alu_a_lo, alu_b, alu_flags_in);
    end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", seen); end
    run_op(3'd0, 16'h0001, 16'h0002, 4'b0100, lat, res, we, fo, lo_op, hi_op, hc);
    checks++; if (lat !== 3) begin errors++; $display("FAIL midrst_fresh_latency got=%0d exp=3", lat); end
    checks++; if (res !== 16'h0003 || fo !== 4'b0100 || we !== 1'b1) begin
      errors++; $display("FAIL midrst_fresh got=%h/%b/%b exp=0003/0100/1", res, fo, we);
    end
  endtask

  initial begin
    test_reset;
    test_addp;
    test_subp_sbcp;
    test_cmpp;
    test_random;
    test_back_to_back;
    test_reserved;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
